sha256_compress: RTL and testbench

- Downstream of the chunk assembly stage. Consumes one padded 512-bit chunk at a time and runs the SHA-256 compression function on it.
- Keeps the running hash H0..H7 across all chunks of one message.
- After the last chunk of a message, presents the 256-bit digest on a valid/ready output.
- The iterative round engine is sized for FPGA area, not throughput.

---
 rtl/sha256_pkg.sv | 64 ++++++
 rtl/sha256_compress_if.sv | 32 +++
 rtl/sha256_round.sv | 25 ++
 rtl/sha256_compress.sv | 119 +++++++++++
 tb/tb_sha256_compress.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// sha256_pkg : SHA-256 constants, word types and FIPS 180-4 logic functions
// Rev 1.0
// ============================================================================
package sha256_pkg;

  typedef logic [31:0]        Word;
  typedef logic [0:7][31:0]   HashState;
  typedef logic [0:15][31:0]  Chunk;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUND  = 2'd1,
    FINAL  = 2'd2,
    DIGEST = 2'd3
  } CompressState;

  localparam HashState IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic Word rotr(input Word x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic Word big_sigma0(input Word x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic Word big_sigma1(input Word x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic Word small_sigma0(input Word x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic Word small_sigma1(input Word x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic Word ch(input Word e, input Word f, input Word g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic Word maj(input Word a, input Word b, input Word c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_compress_if.sv
`default_nettype none
// ============================================================================
// sha256_compress_if : chunk input and digest output handshakes
// Rev 1.0
// ============================================================================
interface sha256_compress_if;
  import sha256_pkg::*;

  logic     chunk_in_rdy;
  logic     chunk_in_vld;
  Chunk     chunk_in;
  logic     chunk_first;
  logic     chunk_last;
  logic     digest_rdy;
  logic     digest_vld;
  HashState digest;

  modport master (
    input  chunk_in_rdy,
    output chunk_in_vld, chunk_in, chunk_first, chunk_last,
    output digest_rdy,
    input  digest_vld, digest
  );

  modport slave (
    output chunk_in_rdy,
    input  chunk_in_vld, chunk_in, chunk_first, chunk_last,
    input  digest_rdy,
    output digest_vld, digest
  );
endinterface
`default_nettype wire

// File: rtl/sha256_round.sv
`default_nettype none
// ============================================================================
// sha256_round : one combinational SHA-256 round, a..h -> a'..h'
// Rev 1.0
// ============================================================================
module sha256_round
  import sha256_pkg::*;
(
  input  HashState i_state,
  input  Word      i_w,
  input  Word      i_k,
  output HashState o_state
);

  Word w_t1;
  Word w_t2;

  assign w_t1 = i_state[7] + big_sigma1(i_state[4]) + ch(i_state[4], i_state[5], i_state[6]) + i_k + i_w;
  assign w_t2 = big_sigma0(i_state[0]) + maj(i_state[0], i_state[1], i_state[2]);

  assign o_state = {w_t1 + w_t2, i_state[0], i_state[1], i_state[2],
                    i_state[3] + w_t1, i_state[4], i_state[5], i_state[6]};

endmodule
`default_nettype wire

// File: rtl/sha256_compress.sv
`default_nettype none
// ============================================================================
// sha256_compress : iterative SHA-256 compression, UNROLL rounds per clock
// Rev 1.0
// ============================================================================
module sha256_compress
  import sha256_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  sha256_compress_if.slave  bus
);

  localparam logic [5:0] c_T_LAST = 6'(64 - UNROLL);

  CompressState r_state;
  CompressState w_state_nx;
  logic         r_rdy;
  logic         r_vld;
  logic         r_last;
  logic [5:0]   r_t;
  HashState     r_h;
  HashState     r_ab;
  HashState     w_ab_nx;
  HashState     w_h_sum;
  Chunk         r_w;
  Chunk         w_w_nx;
  Word          w_ext [0:15+UNROLL];
  logic         w_take;

  assign w_take = bus.chunk_in_vld & r_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rdy   <= 1'b0;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_rdy   <= (w_state_nx == IDLE);
      r_vld   <= (w_state_nx == DIGEST);
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_take) w_state_nx = ROUND;
      ROUND:   if (r_t == c_T_LAST) w_state_nx = FINAL;
      FINAL:   w_state_nx = r_last ? DIGEST : IDLE;
      DIGEST:  if (bus.digest_rdy) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Extend the 16-word window by UNROLL scheduled words, then slide it.
  always_comb begin
    for (int i = 0; i < 16; i++) w_ext[i] = r_w[i];
    for (int i = 16; i < 16 + UNROLL; i++)
      w_ext[i] = small_sigma1(w_ext[i-2]) + w_ext[i-7] + small_sigma0(w_ext[i-15]) + w_ext[i-16];
    for (int i = 0; i < 16; i++) w_w_nx[i] = w_ext[i+UNROLL];
  end

  for (genvar j = 0; j < UNROLL; j++) begin : g_round
    HashState w_in;
    HashState w_out;
    if (j == 0) begin : g_head
      assign w_in = r_ab;
    end else begin : g_link
      assign w_in = g_round[j-1].w_out;
    end
    sha256_round u_round (
      .i_state (w_in),
      .i_w     (r_w[j]),
      .i_k     (K[r_t + 6'(j)]),
      .o_state (w_out)
    );
  end

  assign w_ab_nx = g_round[UNROLL-1].w_out;

  always_comb begin
    for (int i = 0; i < 8; i++) w_h_sum[i] = r_h[i] + r_ab[i];
  end

  always_ff @(posedge clk) begin
    case (r_state)
      IDLE: begin
        if (w_take) begin
          r_w    <= bus.chunk_in;
          r_last <= bus.chunk_last;
          r_t    <= 6'd0;
          r_ab   <= bus.chunk_first ? IV : r_h;
        end
      end
      ROUND: begin
        r_ab <= w_ab_nx;
        r_w  <= w_w_nx;
        r_t  <= r_t + 6'(UNROLL);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                                   r_h <= IV;
    else if (w_take && bus.chunk_first)        r_h <= IV;
    else if (r_state == FINAL)                 r_h <= w_h_sum;
    else if (r_state == DIGEST && bus.digest_rdy) r_h <= IV;
  end

  assign bus.chunk_in_rdy = r_rdy;
  assign bus.digest_vld   = r_vld;
  assign bus.digest       = r_vld ? r_h : '0;

endmodule
`default_nettype wire

// File: tb/tb_sha256_compress.sv
`default_nettype none
// ============================================================================
// tb_sha256_compress : known-answer and randomized checks against a model
// Rev 1.0
// ============================================================================
module tb_sha256_compress;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IVT = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [511:0] CH_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] CH_EMPTY = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] CH_TWO_A = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] CH_TWO_B = {{15{32'h0}}, 32'h000001c0};
  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  sha256_compress_if if1 ();
  sha256_compress_if if2 ();
  sha256_compress_if if4 ();

  sha256_compress #(.UNROLL(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  sha256_compress #(.UNROLL(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
  sha256_compress #(.UNROLL(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference compression: full 64-entry message schedule, then 64 rounds.
  function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] c);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = c[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) v[i] = h[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = h[255-32*i -: 32] + v[i];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [511:0] d, input bit f, input bit l);
    int g = 0;
    if1.chunk_in     = d;
    if1.chunk_first  = f;
    if1.chunk_last   = l;
    if1.chunk_in_vld = 1'b1;
    while (!if1.chunk_in_rdy && g < 300) begin
      @(posedge clk); #1; g++;
    end
    chk("acc_rdy", 256'(if1.chunk_in_rdy), 256'd1);
    @(posedge clk); #1;
    if1.chunk_in_vld = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int  lat  = 1;
    bit  seen = 1'b0;
    while (!if1.chunk_in_rdy && lat < 300) begin
      seen |= if1.digest_vld;
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_rdy_lat"}, 256'(lat), 256'd66);
    chk({tag, "_no_vld"}, 256'(seen), 256'd0);
  endtask

  task automatic get_digest(input string tag, input logic [255:0] exp, input int hold);
    int           lat = 1;
    bit           bad = 1'b0;
    logic [255:0] d0;
    while (!if1.digest_vld && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_lat"}, 256'(lat), 256'd66);
    d0 = if1.digest;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!if1.digest_vld || if1.digest !== d0 || if1.chunk_in_rdy) bad = 1'b1;
    end
    if (hold > 0) chk({tag, "_hold"}, 256'(bad), 256'd0);
    chk({tag, "_dig"}, if1.digest, exp);
    if1.digest_rdy = 1'b1;
    @(posedge clk); #1;
    if1.digest_rdy   = 1'b0;
    if1.chunk_in_vld = 1'b0;
    chk({tag, "_vld_drop"}, 256'(if1.digest_vld), 256'd0);
  endtask

  initial begin
    logic [511:0] c;
    logic [255:0] hm;
    int           nch, lat2, lat4;
    bit           f;
    logic [255:0] dig2, dig4;

    if1.chunk_in_vld = 1'b0; if1.chunk_in = '0; if1.chunk_first = 1'b0;
    if1.chunk_last   = 1'b0; if1.digest_rdy = 1'b0;
    if2.chunk_in_vld = 1'b0; if2.chunk_in = CH_ABC; if2.chunk_first = 1'b1;
    if2.chunk_last   = 1'b1; if2.digest_rdy = 1'b1;
    if4.chunk_in_vld = 1'b0; if4.chunk_in = CH_ABC; if4.chunk_first = 1'b1;
    if4.chunk_last   = 1'b1; if4.digest_rdy = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", 256'(if1.chunk_in_rdy), 256'd0);
    chk("rst_vld", 256'(if1.digest_vld), 256'd0);
    chk("rst_digest", if1.digest, 256'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rdy_after_rst", 256'(if1.chunk_in_rdy), 256'd1);

    send(CH_ABC, 1'b1, 1'b1);
    get_digest("abc", D_ABC, 0);
    send(CH_EMPTY, 1'b1, 1'b1);
    get_digest("empty", D_EMPTY, 0);

    // digest_rdy is held high while no digest is pending; it must do nothing.
    if1.digest_rdy = 1'b1;
    send(CH_TWO_A, 1'b1, 1'b0);
    wait_idle("two_c1");
    if1.digest_rdy = 1'b0;
    send(CH_TWO_B, 1'b0, 1'b1);
    get_digest("two", D_TWO, 0);

    // Backpressure with a pending chunk offered throughout.
    send(CH_ABC, 1'b1, 1'b1);
    if1.chunk_in     = CH_EMPTY;
    if1.chunk_in_vld = 1'b1;
    get_digest("bp", D_ABC, 10);
    send(CH_EMPTY, 1'b1, 1'b1);
    get_digest("bp_empty", D_EMPTY, 0);

    // Reset while round t=30 is being computed.
    send(CH_ABC, 1'b1, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rdy", 256'(if1.chunk_in_rdy), 256'd0);
    chk("midrst_vld", 256'(if1.digest_vld), 256'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_rdy_back", 256'(if1.chunk_in_rdy), 256'd1);
    send(CH_EMPTY, 0, 1'b1);
    get_digest("midrst_empty", D_EMPTY, 0);

    // Randomized multi-chunk messages against the reference model.
    for (int m = 0; m < 8; m++) begin
      nch = $urandom_range(1, 3);
      hm  = IVT;
      for (int k = 0; k < nch; k++) begin
        for (int i = 0; i < 16; i++) c[511-32*i -: 32] = $urandom;
        f = (k == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
        if (f) hm = IVT;
        hm = compress(hm, c);
        send(c, f, k == nch - 1);
        if (k != nch - 1) wait_idle("rnd_mid");
      end
      get_digest("rnd", hm, $urandom_range(0, 3));
    end

    // UNROLL=2 and UNROLL=4 instances on the "abc" chunk.
    chk("u2_rdy", 256'(if2.chunk_in_rdy), 256'd1);
    chk("u4_rdy", 256'(if4.chunk_in_rdy), 256'd1);
    if2.chunk_in_vld = 1'b1;
    if4.chunk_in_vld = 1'b1;
    @(posedge clk); #1;
    if2.chunk_in_vld = 1'b0;
    if4.chunk_in_vld = 1'b0;
    lat2 = 0; lat4 = 0; dig2 = '0; dig4 = '0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (if2.digest_vld && lat2 == 0) begin lat2 = cyc; dig2 = if2.digest; end
      if (if4.digest_vld && lat4 == 0) begin lat4 = cyc; dig4 = if4.digest; end
      @(posedge clk); #1;
    end
    chk("u2_lat", 256'(lat2), 256'd34);
    chk("u2_dig", dig2, D_ABC);
    chk("u4_lat", 256'(lat4), 256'd18);
    chk("u4_dig", dig4, D_ABC);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
